// File: rtl/div_iter_unit.sv
// Multicycle non-restoring integer divider (signed/unsigned) on a start/busy/done handshake.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration phase.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - STEPS);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   rem, rem_step, shifted;
    logic [WIDTH-1:0] quo, quo_step, dvs;
    logic [WIDTH-1:0] dividend_mag, divisor_mag, rem_fix;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, dz_pend, zero_div;

    always_comb begin
        dividend_mag = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
        zero_div     = (divisor == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) begin
`ifdef DIV_ZERO_FAST_EN
                state_next = zero_div ? FINISH : RUN;
`else
                state_next = RUN;
`endif
            end
            RUN:    if (cnt == LAST) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // The decision uses the sign of the remainder before the step; the shifted value may wrap
    // in WIDTH+1 bits but the add/subtract result always lands back in range.
    always_comb begin
        rem_step = rem;
        quo_step = quo;
        shifted  = '0;
        for (int i = 0; i < STEPS; i++) begin
            shifted  = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
            quo_step = {quo_step[WIDTH-2:0], 1'b0};
            if (rem_step[WIDTH]) rem_step = shifted + {1'b0, dvs};
            else                 rem_step = shifted - {1'b0, dvs};
            quo_step[0] = ~rem_step[WIDTH];
        end
    end

    assign rem_fix = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dvs     <= divisor_mag;
                    q_neg   <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg   <= signed_div & dividend[WIDTH-1];
                    dz_pend <= zero_div;
                    cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
                    // Preload exactly what the full iteration would produce for a zero divisor.
                    if (zero_div) begin
                        rem <= {1'b0, dividend_mag};
                        quo <= '1;
                    end else begin
                        rem <= '0;
                        quo <= dividend_mag;
                    end
`else
                    rem <= '0;
                    quo <= dividend_mag;
`endif
                end
                RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + CW'(STEPS);
                end
                FINISH: begin
                    q        <= q_neg ? -quo : quo;
                    r        <= r_neg ? -rem_fix : rem_fix;
                    div_zero <= dz_pend;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit: one STEPS=1 and one STEPS=2 instance, WIDTH=32.
module tb_div_iter_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start1, start2, signed_div;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] q1, r1, q2, r2;
    logic         busy1, busy2, done1, done2, dz1, dz2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(W), .STEPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .q(q1), .r(r1),
        .busy(busy1), .done(done1), .div_zero(dz1)
    );

    div_iter_unit #(.WIDTH(W), .STEPS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .signed_div(signed_div),
        .dividend(dividend), .divisor(divisor), .q(q2), .r(r2),
        .busy(busy2), .done(done2), .div_zero(dz2)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Launches one operation on instance sel and waits (bounded) for its done pulse.
    // A nonzero poke_at fires a second, different start request sampled at that edge.
    task automatic applyStimulus(input int sel, input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int poke_at,
                                 output int latency, output int busy_cycles,
                                 output logic [W-1:0] q_at_start);
        int n;
        @(negedge clk);
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        q_at_start  = (sel == 1) ? q1 : q2;
        busy_cycles = ((sel == 1) ? busy1 : busy2) ? 1 : 0;
        latency     = -1;
        n           = 0;
        while (n < 100 && latency < 0) begin
            if (n + 1 == poke_at) begin
                @(negedge clk);
                signed_div = 1'b0;
                dividend   = 200;
                divisor    = 3;
                if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            start1 = 1'b0;
            start2 = 1'b0;
            if ((sel == 1) ? busy1 : busy2) busy_cycles++;
            if ((sel == 1) ? done1 : done2) latency = n;
        end
    endtask

    int           lat, bcy;
    logic [W-1:0] hq;
    logic         done_seen;

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_q", q1, 0);
        checkOutput("rst_r", r1, 0);
        checkOutput("rst_busy", 32'(busy1), 0);
        checkOutput("rst_done", 32'(done1), 0);
        checkOutput("rst_dz", 32'(dz1), 0);
        @(negedge clk); rst = 1'b0;

        applyStimulus(1, 1'b0, 100, 7, 0, lat, bcy, hq);
        checkOutput("u100_7_q", q1, 14);
        checkOutput("u100_7_r", r1, 2);
        checkOutput("u100_7_lat", 32'(lat), 33);
        checkOutput("u100_7_busy", 32'(bcy), 33);
        checkOutput("u100_7_dz", 32'(dz1), 0);

        applyStimulus(1, 1'b1, 32'hFFFF_FFF9, 2, 0, lat, bcy, hq);
        checkOutput("sm7_2_q", q1, 32'hFFFF_FFFD);
        checkOutput("sm7_2_r", r1, 32'hFFFF_FFFF);
        checkOutput("sm7_2_hold", hq, 14);

        applyStimulus(1, 1'b1, 7, 32'hFFFF_FFFE, 0, lat, bcy, hq);
        checkOutput("s7_m2_q", q1, 32'hFFFF_FFFD);
        checkOutput("s7_m2_r", r1, 1);

        applyStimulus(1, 1'b0, 32'hFFFF_FFF9, 2, 0, lat, bcy, hq);
        checkOutput("u_big_2_q", q1, 32'h7FFF_FFFC);
        checkOutput("u_big_2_r", r1, 1);

        applyStimulus(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcy, hq);
        checkOutput("s_min_m1_q", q1, 32'h8000_0000);
        checkOutput("s_min_m1_r", r1, 0);

        applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 1, 0, lat, bcy, hq);
        checkOutput("u_max_1_q", q1, 32'hFFFF_FFFF);
        checkOutput("u_max_1_r", r1, 0);

        applyStimulus(2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcy, hq);
        checkOutput("s2_min_m1_q", q2, 32'h8000_0000);
        checkOutput("s2_min_m1_r", r2, 0);
        checkOutput("s2_min_m1_lat", 32'(lat), 17);
        checkOutput("s2_min_m1_busy", 32'(bcy), 17);

        applyStimulus(2, 1'b0, 32'hFFFF_FFFF, 1, 0, lat, bcy, hq);
        checkOutput("s2_max_1_q", q2, 32'hFFFF_FFFF);
        checkOutput("s2_max_1_r", r2, 0);
        checkOutput("s2_max_1_lat", 32'(lat), 17);

        applyStimulus(2, 1'b1, 32'hFFFF_FFF9, 2, 0, lat, bcy, hq);
        checkOutput("s2_m7_2_q", q2, 32'hFFFF_FFFD);
        checkOutput("s2_m7_2_r", r2, 32'hFFFF_FFFF);

        applyStimulus(1, 1'b0, 1234, 0, 0, lat, bcy, hq);
        checkOutput("u1234_0_q", q1, 32'hFFFF_FFFF);
        checkOutput("u1234_0_r", r1, 1234);
        checkOutput("u1234_0_dz", 32'(dz1), 1);
        checkOutput("u1234_0_lat", 32'(lat), 32'(ZLAT));

        applyStimulus(1, 1'b0, 9, 3, 0, lat, bcy, hq);
        checkOutput("u9_3_q", q1, 3);
        checkOutput("u9_3_r", r1, 0);
        checkOutput("u9_3_dz", 32'(dz1), 0);

        applyStimulus(1, 1'b1, 32'hFFFF_FFFB, 0, 0, lat, bcy, hq);
        checkOutput("sm5_0_q", q1, 1);
        checkOutput("sm5_0_r", r1, 32'hFFFF_FFFB);
        checkOutput("sm5_0_dz", 32'(dz1), 1);

        // Abort an operation with reset at edge 10 after its start edge.
        @(negedge clk);
        signed_div = 1'b0; dividend = 100; divisor = 7; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        done_seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (done1) done_seen = 1'b1;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_busy", 32'(busy1), 0);
        checkOutput("abort_q", q1, 0);
        checkOutput("abort_r", r1, 0);
        checkOutput("abort_dz", 32'(dz1), 0);
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1) done_seen = 1'b1;
        end
        checkOutput("abort_no_done", 32'(done_seen), 0);

        applyStimulus(1, 1'b0, 50, 5, 0, lat, bcy, hq);
        checkOutput("u50_5_q", q1, 10);
        checkOutput("u50_5_r", r1, 0);

        applyStimulus(1, 1'b0, 100, 7, 5, lat, bcy, hq);
        checkOutput("ignore_q", q1, 14);
        checkOutput("ignore_r", r1, 2);
        checkOutput("ignore_lat", 32'(lat), 33);

        checkOutput("chain_in_done", 32'(done1), 1);
        applyStimulus(1, 1'b0, 81, 9, 0, lat, bcy, hq);
        checkOutput("chain_lat", 32'(lat), 33);
        checkOutput("chain_hold_q", hq, 14);
        checkOutput("chain_q", q1, 9);
        checkOutput("chain_r", r1, 0);

        @(posedge clk); #1;
        checkOutput("done_pulse_end", 32'(done1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
